// File: rtl/addr_decoder_n_if.sv
// Bus bundle between a master's serial address port, the decoder and the slave ports.
interface addr_decoder_n_if #(
  parameter int NUM_SLAVES = 3,
  parameter int SEL_WIDTH  = $clog2(NUM_SLAVES)
);
  logic                  mwdata;
  logic                  mvalid;
  logic                  ssplit;
  logic                  split_grant;
  logic [NUM_SLAVES-1:0] sready;
  logic [NUM_SLAVES-1:0] mvalid_o;
  logic [SEL_WIDTH-1:0]  ssel;
  logic                  ack;
  logic                  dec_err;
  logic                  timeout;
  logic                  split_pending;

  // Environment side: the bus master plus the slaves' ready/split lines.
  modport master (
    output mwdata, mvalid, ssplit, split_grant, sready,
    input  mvalid_o, ssel, ack, dec_err, timeout, split_pending
  );

  modport slave (
    input  mwdata, mvalid, ssplit, split_grant, sready,
    output mvalid_o, ssel, ack, dec_err, timeout, split_pending
  );
endinterface

// File: rtl/addr_decoder_n.sv
// Serial (LSB-first) slave-address decoder with one-hot valid routing,
// single-entry split save/resume and optional WAIT timeout.
module addr_decoder_n #(
  parameter int NUM_SLAVES        = 3,
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int SEL_WIDTH         = $clog2(NUM_SLAVES),
  parameter int TIMEOUT_CYCLES    = 0
) (
  input logic             clk,
  input logic             rstn,
  addr_decoder_n_if.slave bus
);

  localparam int W      = DEVICE_ADDR_WIDTH;
  localparam int CNT_W  = $clog2(W);
  localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(W - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST =
    WCNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_CONNECT,
    S_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          addr_q, addr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SEL_WIDTH-1:0]  ssel_q, ssel_d;
  logic [W-1:0]          split_addr_q, split_addr_d;
  logic                  split_pend_q, split_pend_d;
  logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;

  logic                  addr_rdy;
  logic                  ack_c;
  logic                  dec_err_c;
  logic                  timeout_c;
  logic [NUM_SLAVES-1:0] mvalid_o_c;

  // Only in-range addresses ever select an sready bit; others read as not ready.
  always_comb begin
    addr_rdy = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (addr_q == W'(i)) addr_rdy = bus.sready[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bit_cnt_d    = bit_cnt_q;
    ssel_d       = ssel_q;
    split_addr_d = split_addr_q;
    split_pend_d = split_pend_q;
    wait_cnt_d   = wait_cnt_q;
    ack_c        = 1'b0;
    dec_err_c    = 1'b0;
    timeout_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.mvalid) begin
          addr_d[0] = bus.mwdata;
          bit_cnt_d = CNT_W'(1);
          state_d   = S_ADDR;
        end else if (bus.split_grant && split_pend_q) begin
          addr_d       = split_addr_q;
          ssel_d       = split_addr_q[SEL_WIDTH-1:0];
          split_pend_d = 1'b0;
          wait_cnt_d   = '0;
          state_d      = S_WAIT;
        end
      end

      S_ADDR: begin
        for (int unsigned i = 0; i < W; i++) begin
          if (bit_cnt_q == CNT_W'(i)) addr_d[i] = bus.mwdata;
        end
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          ssel_d    = addr_d[SEL_WIDTH-1:0];
          state_d   = S_CONNECT;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      S_CONNECT: begin
        if (addr_rdy) begin
          ack_c = 1'b1;
          if (bus.mvalid) begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end
        end else begin
          dec_err_c = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_WAIT: begin
        // Split beats ready, and any exit condition beats the timeout.
        if (bus.ssplit) begin
          split_addr_d = addr_q;
          split_pend_d = 1'b1;
          state_d      = S_IDLE;
        end else if (addr_rdy) begin
          state_d = S_IDLE;
        end else if ((TIMEOUT_CYCLES > 0) && (wait_cnt_q == WAIT_LAST)) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mvalid_o_c = '0;
    if (state_q == S_WAIT) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        mvalid_o_c[i] = bus.mvalid & (ssel_q == SEL_WIDTH'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      bit_cnt_q    <= '0;
      ssel_q       <= '0;
      split_addr_q <= '0;
      split_pend_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bit_cnt_q    <= bit_cnt_d;
      ssel_q       <= ssel_d;
      split_addr_q <= split_addr_d;
      split_pend_q <= split_pend_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.mvalid_o      = mvalid_o_c;
  assign bus.ssel          = ssel_q;
  assign bus.ack           = ack_c;
  assign bus.dec_err       = dec_err_c;
  assign bus.timeout       = timeout_c;
  assign bus.split_pending = split_pend_q;

endmodule

// File: tb/tb_addr_decoder_n.sv
// Directed bench: 3-slave/4-bit/timeout-8 decoder and 6-slave/3-bit/no-timeout decoder.
module tb_addr_decoder_n;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  addr_decoder_n_if #(.NUM_SLAVES(3)) bus_a ();
  addr_decoder_n_if #(.NUM_SLAVES(6)) bus_b ();

  addr_decoder_n #(
    .NUM_SLAVES       (3),
    .DEVICE_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES   (8)
  ) dut_a (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_a)
  );

  addr_decoder_n #(
    .NUM_SLAVES       (6),
    .DEVICE_ADDR_WIDTH(3),
    .TIMEOUT_CYCLES   (0)
  ) dut_b (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one LSB-first address on bus A; returns at the negedge of the CONNECT cycle.
  task automatic send_addr_a(input int a);
    logic [3:0] v;
    v = 4'(a);
    for (int i = 0; i < 4; i++) begin
      bus_a.mvalid = (i == 0);
      bus_a.mwdata = v[i];
      @(negedge clk);
    end
    bus_a.mwdata = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] vb;
    n_checks = 0;
    n_fail   = 0;
    rstn = 1'b0;
    bus_a.mwdata = 0; bus_a.mvalid = 0; bus_a.ssplit = 0; bus_a.split_grant = 0; bus_a.sready = '0;
    bus_b.mwdata = 0; bus_b.mvalid = 0; bus_b.ssplit = 0; bus_b.split_grant = 0; bus_b.sready = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_mvalid_o", bus_a.mvalid_o, 0);
    check("rst_a_ssel",     bus_a.ssel, 0);
    check("rst_a_ack",      bus_a.ack, 0);
    check("rst_a_dec_err",  bus_a.dec_err, 0);
    check("rst_a_timeout",  bus_a.timeout, 0);
    check("rst_a_split",    bus_a.split_pending, 0);
    check("rst_b_mvalid_o", bus_b.mvalid_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Address 2, hold once in CONNECT, then WAIT until slave 2 ready.
    send_addr_a(2);
    bus_a.mvalid = 0; bus_a.sready = 3'b111; #1;
    check("t1_ack_hold", bus_a.ack, 1);
    check("t1_ssel",     bus_a.ssel, 2);
    check("t1_mvo_conn", bus_a.mvalid_o, 0);
    @(negedge clk);
    bus_a.mvalid = 1; #1;
    check("t1_ack_go", bus_a.ack, 1);
    @(negedge clk);
    bus_a.sready = 3'b011; #1;
    check("t1_mvo_wait", bus_a.mvalid_o, 3'b100);
    check("t1_ack_wait", bus_a.ack, 0);
    @(negedge clk);
    bus_a.sready = 3'b111; #1;
    check("t1_mvo_wait2", bus_a.mvalid_o, 3'b100);
    @(negedge clk);
    bus_a.mvalid = 0; #1;
    check("t1_mvo_idle", bus_a.mvalid_o, 0);
    @(negedge clk);

    // Address 5 is beyond NUM_SLAVES=3.
    send_addr_a(5);
    bus_a.mvalid = 1; bus_a.sready = 3'b111; #1;
    check("t2_dec_err", bus_a.dec_err, 1);
    check("t2_ack",     bus_a.ack, 0);
    check("t2_mvo",     bus_a.mvalid_o, 0);
    @(negedge clk);
    bus_a.mvalid = 0; #1;
    check("t2_dec_err_pulse", bus_a.dec_err, 0);
    check("t2_mvo_idle",      bus_a.mvalid_o, 0);
    @(negedge clk);

    // Address 1, split together with ready in WAIT: split wins.
    send_addr_a(1);
    bus_a.mvalid = 1; #1;
    check("t3_ack", bus_a.ack, 1);
    @(negedge clk);
    bus_a.ssplit = 1; #1;
    check("t3_mvo_wait", bus_a.mvalid_o, 3'b010);
    @(negedge clk);
    bus_a.ssplit = 0; bus_a.mvalid = 0; #1;
    check("t3_split_pend", bus_a.split_pending, 1);
    check("t3_mvo_idle",   bus_a.mvalid_o, 0);

    // New address shift beats split_grant; split stays pending.
    bus_a.split_grant = 1;
    send_addr_a(0);
    bus_a.split_grant = 0; bus_a.mvalid = 1; #1;
    check("t4_split_kept", bus_a.split_pending, 1);
    check("t4_ack",        bus_a.ack, 1);
    check("t4_ssel",       bus_a.ssel, 0);
    @(negedge clk);
    #1;
    check("t4_mvo_wait", bus_a.mvalid_o, 3'b001);
    @(negedge clk);
    bus_a.mvalid = 0; bus_a.split_grant = 1; #1;
    check("t4_pend_idle", bus_a.split_pending, 1);
    @(negedge clk);
    bus_a.split_grant = 0; bus_a.mvalid = 1; bus_a.sready = 3'b101; #1;
    check("t4_resume_ssel", bus_a.ssel, 1);
    check("t4_resume_pend", bus_a.split_pending, 0);
    check("t4_resume_mvo",  bus_a.mvalid_o, 3'b010);
    @(negedge clk);
    bus_a.sready = 3'b111; #1;
    check("t4_resume_mvo2", bus_a.mvalid_o, 3'b010);
    @(negedge clk);
    bus_a.mvalid = 0; @(negedge clk);

    // Timeout: slave never ready, pulse on the 8th WAIT cycle.
    send_addr_a(0);
    bus_a.mvalid = 1; bus_a.sready = 3'b111; @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      bus_a.sready = 3'b000; #1;
      check($sformatf("t5_timeout_c%0d", k), bus_a.timeout, (k == 8) ? 1 : 0);
      @(negedge clk);
    end
    bus_a.mvalid = 1; bus_a.mwdata = 0; #1;
    check("t5_mvo_after", bus_a.mvalid_o, 0);
    check("t5_to_after",  bus_a.timeout, 0);
    check("t5_pend_kept", bus_a.split_pending, 0);
    @(negedge clk);
    bus_a.mvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    check("t5_notready_dec_err", bus_a.dec_err, 1);
    @(negedge clk);

    // Ready arriving on the 8th WAIT cycle suppresses the timeout.
    send_addr_a(0);
    bus_a.mvalid = 1; bus_a.sready = 3'b111; @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      bus_a.sready = (k == 8) ? 3'b001 : 3'b000; #1;
      check($sformatf("t6_no_timeout_c%0d", k), bus_a.timeout, 0);
      @(negedge clk);
    end
    bus_a.mvalid = 0; bus_a.sready = 3'b000; #1;
    check("t6_to_after", bus_a.timeout, 0);
    @(negedge clk);

    // Leave a split pending on A so reset must clear it.
    send_addr_a(2);
    bus_a.mvalid = 1; bus_a.sready = 3'b111; @(negedge clk);
    bus_a.ssplit = 1; bus_a.sready = 3'b011; @(negedge clk);
    bus_a.ssplit = 0; bus_a.mvalid = 0; #1;
    check("t7_split_pend", bus_a.split_pending, 1);

    // Decoder B: address 5 routes to mvalid_o[5]; no timeout when disabled.
    vb = 3'd5;
    for (int i = 0; i < 3; i++) begin
      bus_b.mvalid = (i == 0);
      bus_b.mwdata = vb[i];
      @(negedge clk);
    end
    bus_b.mvalid = 1; bus_b.sready = 6'h3f; #1;
    check("b_ack",  bus_b.ack, 1);
    check("b_ssel", bus_b.ssel, 5);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      bus_b.sready = 6'h00; #1;
      check($sformatf("b_mvo_c%0d", k), bus_b.mvalid_o, 6'h20);
      check($sformatf("b_no_to_c%0d", k), bus_b.timeout, 0);
      @(negedge clk);
    end
    #1;
    rstn = 1'b0; #1;
    check("b_rst_mvo",    bus_b.mvalid_o, 0);
    check("b_rst_ssel",   bus_b.ssel, 0);
    check("b_rst_ack",    bus_b.ack, 0);
    check("a_rst_split",  bus_a.split_pending, 0);
    check("a_rst_ssel",   bus_a.ssel, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_decoder_n.md
# addr_decoder_n

Parametrised serial-address decoder for the system bus, sitting between a master's bus interface and NUM_SLAVES slave ports. It deserialises the LSB-first slave-select address shifted in on `mwdata`, checks that the target exists and is ready, and grants with `ack`. It then routes `mvalid` one-hot to the selected slave. It saves the target of a split transaction and resumes it on `split_grant`. It also reports decode errors and WAIT-state timeouts.

## Interface
- `NUM_SLAVES`, 3: number of slave ports (≥2).
- `DEVICE_ADDR_WIDTH`, 4: serial slave-address bits (≥2); must satisfy 2^DEVICE_ADDR_WIDTH ≥ NUM_SLAVES.
- `SEL_WIDTH`, $clog2(NUM_SLAVES): width of `ssel`; derived, not overridden.
- `TIMEOUT_CYCLES`, 0: WAIT-state cycle limit; 0 disables the timeout.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rstn` in 1: reset; asynchronous and active-low.
- `mwdata` in 1: serial address bit, LSB first.
- `mvalid` in 1: master valid.
- `ssplit` in 1: addressed slave splits the current transaction.
- `split_grant` in 1: arbiter resumes the saved split transaction.
- `sready` in NUM_SLAVES: per-slave ready; bit i belongs to slave i.
- `mvalid_o` out NUM_SLAVES: one-hot gated `mvalid` per slave.
- `ssel` out SEL_WIDTH: registered select for the read-data mux.
- `ack` out 1: address accepted.
- `dec_err` out 1: one-cycle pulse; invalid or not-ready target.
- `timeout` out 1: one-cycle pulse; WAIT limit expired.
- `split_pending` out 1: a split address is saved.

## Operation
- States: IDLE, ADDR, CONNECT, WAIT. Reset state is IDLE.
- IDLE:
  - `mvalid`=1: `addr[0]`←`mwdata`, bit counter←1, go to ADDR. This has priority over `split_grant`.
  - Else `split_grant`=1 and `split_pending`=1: `addr`←saved split address, `ssel`←its low SEL_WIDTH bits, clear `split_pending`, go to WAIT.
  - `split_grant` while `split_pending`=0 is ignored.
- ADDR:
  - `addr[counter]`←`mwdata`, counter+1.
  - When counter = DEVICE_ADDR_WIDTH-1: capture that bit, counter←0, `ssel`←new address truncated to SEL_WIDTH bits, go to CONNECT.
- CONNECT: target valid ⇔ `addr` < NUM_SLAVES and `sready[addr]`=1.
  - Invalid: `dec_err`=1 for this cycle, go to IDLE.
  - Valid: `ack`=1 (combinational) for every CONNECT cycle. Go to WAIT when `mvalid`=1, else hold.
- WAIT:
  - `mvalid_o[ssel]` = `mvalid`; all other bits are 0.
  - Exit to IDLE when `sready[addr]` | `ssplit`.
  - On `ssplit`: save `addr`, set `split_pending`. A new split overwrites the saved address, so only one split is tracked.
  - `sready` and `ssplit` in the same cycle: split wins; save and set.
- Timeout (TIMEOUT_CYCLES>0):
  - Wait counter clears on WAIT entry and increments each WAIT cycle.
  - If counter reaches TIMEOUT_CYCLES-1 with no exit condition: `timeout`=1 that cycle, go to IDLE, `split_pending` unchanged.
  - An exit condition in the same cycle takes priority; `timeout` stays 0.
- `mvalid_o` is all-zero in every state except WAIT.
- Out-of-range address: never index `sready` beyond NUM_SLAVES-1; treat the target as not ready.

## Timing
- Reset values: state IDLE, `addr`=0, counters=0, saved split address=0. Outputs: `ssel`=0, `split_pending`=0, `mvalid_o`=0, `ack`=0, `dec_err`=0, `timeout`=0.
- `rstn` asserted mid-transaction: immediate return to reset values, including a pending split.
- Address phase takes DEVICE_ADDR_WIDTH cycles: 1 in IDLE plus DEVICE_ADDR_WIDTH-1 in ADDR. CONNECT is the next cycle.
- `ack` and `dec_err` are combinational from state, `addr` and `sready`. No latency beyond CONNECT.
- `ssel` is valid from the first CONNECT cycle (or first WAIT cycle after a resume) and holds until the next load.
- Split resume: `split_grant` in IDLE → WAIT on the next cycle, with `mvalid_o` live.

## Test plan
- Addr 2, W=4 (bits 0,1,0,0), `sready`=3'b111 → `ack` high in cycle 5. `mvalid` then drives `mvalid_o`=3'b100 in WAIT. `sready[2]` → IDLE.
- Addr 5 with NUM_SLAVES=3 → single `dec_err` pulse in CONNECT, no `ack`, `mvalid_o`=0, back to IDLE.
- Addr 1 with `ssplit` in WAIT → `split_pending`=1, IDLE. Later `split_grant` → WAIT with `ssel`=1 and `split_pending`=0.
- `mvalid` and `split_grant` together in IDLE with a pending split → new address shift wins, split stays pending.
- TIMEOUT_CYCLES=8, `sready` held low in WAIT → `timeout` pulses on the 8th WAIT cycle, then IDLE. `sready` rising on the 8th cycle → no `timeout`.
- NUM_SLAVES=6, W=3: addr 5 routed to `mvalid_o[5]`. `rstn` dropped in WAIT → all outputs 0 asynchronously.
